// File: rtl/squeeze_ctrl.sv
// squeeze_ctrl: squeeze-phase sequencer for the Keccak core.
// Decides how many rate blocks are handed to dump_stage, requests extra
// squeeze permutations between blocks, gates delivery of exactly the
// requested number of words and flushes any surplus buffered words.
// Optional feature macro: SQUEEZE_CTRL_ABORT_EN (adds abort/aborted ports).
module squeeze_ctrl #(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] out_len_words,
  input  logic [1:0]       mode_in,
  input  logic             perm_done,
  input  logic             dump_available,
  input  logic             word_accepted,
`ifdef SQUEEZE_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             perm_req,
  output logic             output_buffer_we,
  output logic [1:0]       operation_mode,
  output logic             word_valid_gate,
  output logic             last_word,
  output logic             flush_ready,
  output logic             busy,
  output logic             done
);

  // Rate in words for each mode, derived from the rate in bits and lane width
  localparam int unsigned RATE_128 = 1344 / W;
  localparam int unsigned RATE_256 = 1088 / W;
  localparam int unsigned RATE_512 = 576 / W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_STATE,
    S_WAIT_BUF,
    S_LOAD,
    S_PERMUTE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] tgt_q;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] delivered_q;

  logic [LEN_W-1:0] rw;
  logic [LEN_W-1:0] take;
  logic [LEN_W-1:0] rem_after;
  logic [LEN_W-1:0] start_tgt;
  logic             abort_go;
  logic             count_word;

`ifdef SQUEEZE_CTRL_ABORT_EN
  logic             abort_seen_q;
`endif

  // Block sizing, target selection and next-state decision
  always_comb begin
    case (mode_q)
      2'b00:   rw = LEN_W'(RATE_128);
      2'b11:   rw = LEN_W'(RATE_512);
      default: rw = LEN_W'(RATE_256);
    endcase

    take      = (remaining_q < rw) ? remaining_q : rw;
    rem_after = remaining_q - take;

    case (mode_in)
      2'b10:   start_tgt = LEN_W'(4);
      2'b11:   start_tgt = LEN_W'(8);
      default: start_tgt = out_len_words;
    endcase

`ifdef SQUEEZE_CTRL_ABORT_EN
    abort_go = abort && (state_q != S_IDLE) && (state_q != S_FLUSH) &&
               (state_q != S_DONE);
`else
    abort_go = 1'b0;
`endif

    count_word = word_accepted && (state_q != S_IDLE) && (delivered_q < tgt_q);

    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_nxt = (start_tgt == '0) ? S_FLUSH : S_WAIT_STATE;
      end
      S_WAIT_STATE: begin
        if (perm_done) state_nxt = S_WAIT_BUF;
      end
      S_WAIT_BUF: begin
        if (dump_available) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = (rem_after != '0) ? S_PERMUTE : S_DRAIN;
      end
      S_PERMUTE: begin
        if (perm_done) state_nxt = S_WAIT_BUF;
      end
      S_DRAIN: begin
        if (delivered_q == tgt_q) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (dump_available) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // abort overrides every other transition; a perm_done in flight is dropped
    if (abort_go) state_nxt = S_FLUSH;
  end

  // State, counters and registered FSM outputs (decoded from the next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      mode_q           <= '0;
      tgt_q            <= '0;
      remaining_q      <= '0;
      delivered_q      <= '0;
      perm_req         <= 1'b0;
      output_buffer_we <= 1'b0;
      flush_ready      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
`ifdef SQUEEZE_CTRL_ABORT_EN
      abort_seen_q     <= 1'b0;
      aborted          <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;

      if ((state_q == S_IDLE) && start) begin
        mode_q      <= mode_in;
        tgt_q       <= start_tgt;
        remaining_q <= start_tgt;
        delivered_q <= '0;
      end else begin
        if (state_q == S_LOAD) remaining_q <= rem_after;
        if (count_word) delivered_q <= delivered_q + LEN_W'(1);
      end

      perm_req         <= (state_nxt == S_PERMUTE);
      output_buffer_we <= (state_nxt == S_LOAD);
      flush_ready      <= (state_nxt == S_FLUSH);
      busy             <= (state_nxt != S_IDLE);
      done             <= (state_nxt == S_DONE);

`ifdef SQUEEZE_CTRL_ABORT_EN
      if ((state_q == S_IDLE) && start) abort_seen_q <= 1'b0;
      else if (abort_go)                abort_seen_q <= 1'b1;
      aborted <= (state_nxt == S_DONE) && abort_seen_q;
`endif
    end
  end

  assign operation_mode  = mode_q;
  assign last_word       = busy && (tgt_q != '0) && (delivered_q == (tgt_q - LEN_W'(1)));
  assign word_valid_gate = busy && (delivered_q < tgt_q) && (state_q != S_FLUSH);

endmodule

// File: tb/tb_squeeze_ctrl.sv
// tb_squeeze_ctrl: randomized self-checking bench for squeeze_ctrl.
// The bench plays the permutation core and the dump stage / consumer and
// checks transaction-level totals (loads, handshakes, words, done) plus the
// per-cycle gate/last_word rules against a word-count model.
module tb_squeeze_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] out_len_words;
  logic [1:0]  mode_in;
  logic        perm_done;
  logic        dump_available;
  logic        word_accepted;
  logic        perm_req;
  logic        output_buffer_we;
  logic [1:0]  operation_mode;
  logic        word_valid_gate;
  logic        last_word;
  logic        flush_ready;
  logic        busy;
  logic        done;
`ifdef SQUEEZE_CTRL_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  squeeze_ctrl #(.LEN_W(16), .W(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .out_len_words    (out_len_words),
    .mode_in          (mode_in),
    .perm_done        (perm_done),
    .dump_available   (dump_available),
    .word_accepted    (word_accepted),
`ifdef SQUEEZE_CTRL_ABORT_EN
    .abort            (abort),
    .aborted          (aborted),
`endif
    .perm_req         (perm_req),
    .output_buffer_we (output_buffer_we),
    .operation_mode   (operation_mode),
    .word_valid_gate  (word_valid_gate),
    .last_word        (last_word),
    .flush_ready      (flush_ready),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int ref_tgt(input logic [1:0] m, input int len);
    case (m)
      2'b10:   return 4;
      2'b11:   return 8;
      default: return len;
    endcase
  endfunction

  function automatic int ref_rw(input logic [1:0] m);
    case (m)
      2'b00:   return 21;
      2'b11:   return 9;
      default: return 17;
    endcase
  endfunction

  function automatic logic [31:0] out_vec();
    return {23'd0, perm_req, output_buffer_we, flush_ready, busy, done,
            word_valid_gate, last_word, operation_mode};
  endfunction

  // One squeeze run. do_rst asserts reset on the first cycle perm_req is seen.
  task automatic run_one(input logic [1:0] m, input int len, input bit dump_always, input bit do_rst);
    int tgt, rw, exp_loads, exp_perms;
    int loads, rises, acc, avail, pd_timer, done_seen;
    int first_pd_cyc, first_we_cyc, start_cyc, done_cyc;
    bit prev_req, finished;

    tgt       = ref_tgt(m, len);
    rw        = ref_rw(m);
    exp_loads = (tgt == 0) ? 0 : (tgt + rw - 1) / rw;
    exp_perms = (exp_loads == 0) ? 0 : exp_loads - 1;
    loads = 0; rises = 0; acc = 0; avail = 0; done_seen = 0;
    first_pd_cyc = -1; first_we_cyc = -1; done_cyc = -1;
    prev_req = 1'b0; finished = 1'b0;

    mode_in       = m;
    out_len_words = len[15:0];
    start         = 1'b1;
    start_cyc     = cyc;
    tick();
    start         = 1'b0;
    mode_in       = 2'($urandom);
    out_len_words = 16'($urandom);
    pd_timer      = (tgt == 0) ? 0 : 1 + int'($urandom % 4);

    for (int n = 0; n < 4000 && !finished; n++) begin
      // observe
      if (do_rst && perm_req) begin
        rst = 1'b1; start = 1'b0; perm_done = 1'b0; word_accepted = 1'b0;
        tick();
        check_eq("rst_mid_outputs", out_vec(), 32'd0);
        rst = 1'b0;
        return;
      end
      if (output_buffer_we) begin
        loads++;
        avail += rw;
        if (first_we_cyc < 0) first_we_cyc = cyc;
        check_eq("mode_at_load", 32'(operation_mode), 32'(m));
      end
      if (perm_req && !prev_req) begin
        rises++;
        pd_timer = 1 + int'($urandom % 4);
      end
      prev_req = perm_req;
      if (busy && !done) begin
        check_eq("gate", 32'(word_valid_gate), 32'(!flush_ready && (acc < tgt)));
        check_eq("last_word", 32'(last_word), 32'((tgt != 0) && (acc == tgt - 1)));
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        finished = 1'b1;
`ifdef SQUEEZE_CTRL_ABORT_EN
        check_eq("aborted_clean", 32'(aborted), 32'd0);
`endif
      end
      // drive
      if (!finished) begin
        perm_done = (pd_timer == 1);
        if (perm_done && first_pd_cyc < 0) first_pd_cyc = cyc;
        if (pd_timer > 0) pd_timer--;
        dump_available = dump_always ? 1'b1 : ($urandom % 4 != 0);
        word_accepted  = word_valid_gate && (avail > 0) && ($urandom % 3 != 0);
        if (word_accepted) begin
          acc++;
          avail--;
        end
        start         = busy && ($urandom % 8 == 0);
        out_len_words = 16'($urandom);
        tick();
      end
    end
    start = 1'b0; perm_done = 1'b0; word_accepted = 1'b0;

    check_eq("done_count", 32'(done_seen), 32'd1);
    check_eq("loads", 32'(loads), 32'(exp_loads));
    check_eq("perm_handshakes", 32'(rises), 32'(exp_perms));
    check_eq("words_delivered", 32'(acc), 32'(tgt));
    if (dump_always && tgt > 0)
      check_eq("pd_to_load_latency", 32'(first_we_cyc - first_pd_cyc), 32'd2);
    if (dump_always && tgt == 0)
      check_eq("zero_len_done_latency", 32'(done_cyc - start_cyc), 32'd2);
    tick();
    check_eq("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

`ifdef SQUEEZE_CTRL_ABORT_EN
  task automatic run_abort();
    int n;
    mode_in = 2'b01; out_len_words = 16'd40; dump_available = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    n = 0;
    while (!output_buffer_we && n < 20) begin
      tick();
      n++;
    end
    check_eq("abort_first_load", 32'(output_buffer_we), 32'd1);
    tick();
    check_eq("abort_perm_req", 32'(perm_req), 32'd1);
    dump_available = 1'b0;
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    check_eq("abort_in_wait_buf", {30'd0, perm_req, flush_ready}, 32'd0);
    abort = 1'b1;
    perm_done = 1'b1;
    tick();
    abort = 1'b0;
    perm_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("abort_flushing", {29'd0, flush_ready, perm_req, done}, 32'd4);
      tick();
    end
    dump_available = 1'b1;
    tick();
    check_eq("abort_done", {30'd0, done, aborted}, 32'd3);
    tick();
    check_eq("abort_idle", {29'd0, done, aborted, busy}, 32'd0);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; out_len_words = '0; mode_in = '0;
    perm_done = 1'b0; dump_available = 1'b0; word_accepted = 1'b0;
`ifdef SQUEEZE_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    check_eq("reset_outputs", out_vec(), 32'd0);
    rst = 1'b0;
    tick();

    run_one(2'b00, 5,   1'b1, 1'b0);
    run_one(2'b01, 40,  1'b0, 1'b0);
    run_one(2'b11, 100, 1'b1, 1'b0);
    run_one(2'b00, 0,   1'b1, 1'b0);
    run_one(2'b10, 77,  1'b1, 1'b0);
    run_one(2'b00, 21,  1'b1, 1'b0);
    run_one(2'b00, 22,  1'b0, 1'b0);
    run_one(2'b01, 40,  1'b0, 1'b1);
    run_one(2'b01, 20,  1'b0, 1'b0);
`ifdef SQUEEZE_CTRL_ABORT_EN
    run_abort();
    run_one(2'b00, 3,   1'b1, 1'b0);
`endif
    for (int r = 0; r < 30; r++)
      run_one(2'($urandom), int'($urandom % 70), bit'($urandom % 2), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
